// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, checksummed program into instruction memory,
// pads the remainder with FILL_BYTE and releases the CPU only after a verified load.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0] FILL_BYTE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_byte,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int LW = DATA_WIDTH > CW ? DATA_WIDTH : CW;
    localparam logic [LW-1:0] DEPTH = LW'(MEM_DEPTH);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0]            state;
    logic [LW-1:0]         len;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sum;
    logic                  accept;
    logic [LW-1:0]         cnt_inc;
    logic [LW-1:0]         len_in;

    assign accept  = in_valid && in_ready;
    assign cnt_inc = LW'(cnt) + LW'(1);
    assign len_in  = LW'(in_byte);

    // cnt is one bit wider than the address so a full-depth image ends at MEM_DEPTH, not 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            len      <= '0;
            cnt      <= '0;
            sum      <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cnt      <= '0;
                        sum      <= '0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        len <= len_in;
                        if (len_in > DEPTH) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= (len_in == '0) ? S_CSUM : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt[ADDR_WIDTH-1:0];
                        wr_data <= in_byte;
                        cnt     <= cnt + 1'b1;
                        sum     <= sum + in_byte;
                        if (cnt_inc == len) state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_byte != sum) begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else if (LW'(cnt) == DEPTH) begin
                            state    <= S_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state   <= S_FILL;
                            wr_en   <= 1'b1;
                            wr_addr <= cnt[ADDR_WIDTH-1:0];
                            wr_data <= FILL_BYTE;
                            cnt     <= cnt + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (LW'(cnt) == DEPTH) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt[ADDR_WIDTH-1:0];
                        wr_data <= FILL_BYTE;
                        cnt     <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; expected memory writes are queued as bytes are driven
// and popped as the loader writes them.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = '0;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       error;
    logic       cpu_hold;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    logic [7:0]  prog[$];

    imem_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_wr", exp_q.size(), 1);
            end else begin
                exp_w = exp_q.pop_front();
                check("wr_addr", {24'b0, wr_addr}, {24'b0, exp_w[15:8]});
                check("wr_data", {24'b0, wr_data}, {24'b0, exp_w[7:0]});
            end
        end
    end

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_byte = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", n < 50, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input logic [7:0] cs, input int maxgap);
        logic [7:0] s;
        int         n;
        int         len;
        s = '0;
        len = prog.size();
        pulse_start();
        check("start_busy", busy, 1);
        check("start_ready", in_ready, 1);
        check("start_done", done, 0);
        check("start_error", error, 0);
        send(8'(len), 0);
        foreach (prog[i]) begin
            exp_q.push_back({8'(i), prog[i]});
            s += prog[i];
            send(prog[i], maxgap > 0 ? int'($urandom_range(1, maxgap)) : 0);
        end
        if (cs == s)
            for (int a = len; a < 256; a++) exp_q.push_back({8'(a), 8'h00});
        send(cs, maxgap > 0 ? int'($urandom_range(1, maxgap)) : 0);
        if (cs == s) begin
            n = 0;
            while (busy && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("fill_cycles", n, 256 - len);
            check("good_done", done, 1);
            check("good_cpu_hold", cpu_hold, 0);
            check("good_error", error, 0);
            check("good_in_ready", in_ready, 0);
        end else begin
            check("bad_error", error, 1);
            check("bad_busy", busy, 0);
            check("bad_done", done, 0);
            check("bad_cpu_hold", cpu_hold, 1);
            check("bad_in_ready", in_ready, 0);
            repeat (5) @(negedge clk);
        end
        check("sb_drain", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle_reset("reset");
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        in_valid = 1'b1;
        in_byte = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check_idle_reset("no_start");

        prog = '{8'hA1, 8'hB2, 8'hC3};
        load(8'h16, 0);

        load(8'h17, 0);

        prog = '{};
        load(8'h00, 0);

        prog = '{8'h10, 8'h20};
        load(8'h30, 3);

        pulse_start();
        send(8'd4, 0);
        exp_q.push_back({8'd0, 8'h11});
        send(8'h11, 0);
        pulse_start();
        check("ign_start_busy", busy, 1);
        check("ign_start_ready", in_ready, 1);
        exp_q.push_back({8'd1, 8'h22});
        send(8'h22, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_reset("midload_rst");
        check("midload_sb", exp_q.size(), 0);

        prog = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'h80};
        load(8'h85, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the Redux-V instruction memory.
- Receives a length-prefixed, checksummed program byte stream over a valid/ready handshake.
- Writes the program into the instruction memory write port from address 0 upward, then pads the remaining addresses with a fill byte.
- Holds the CPU (PC and core) in hold until a complete, checksum-verified image is resident.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width.
- DATA_WIDTH, 8, instruction width (one instruction per byte).
- MEM_DEPTH, 256, number of memory words; must be ≤ 2^ADDR_WIDTH.
- FILL_BYTE, 8'h00, value written to every address not covered by the program.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when not busy.
- in_valid  in  1  in_byte holds a valid stream byte.
- in_byte  in  DATA_WIDTH  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_WIDTH  memory write address.
- wr_data  out  DATA_WIDTH  memory write data.
- busy  out  1  load in progress.
- done  out  1  last load completed with a good checksum.
- error  out  1  last load failed (bad checksum or bad length).
- cpu_hold  out  1  keep PC/core stalled.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; no asynchronous reset anywhere.
- Stream format: LEN byte N, then N data bytes, then one CSUM byte.
  - CSUM must equal the sum of the N data bytes mod 256.
- A byte is accepted only on a cycle with in_valid && in_ready. Cycles without acceptance have no effect.
- All outputs are registered.
- Reset values: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, error 0, cpu_hold 1.
- A reset mid-load returns all outputs to the reset values at the next edge. Memory contents are then undefined; cpu_hold stays 1.
- States and transitions:
  - IDLE/DONE/ERR: on start go to LEN. Going to LEN sets busy=1, cpu_hold=1, done=0, error=0, clears the address counter and the running sum.
  - LEN (in_ready=1): on accept, latch N.
    - If N > MEM_DEPTH, go to ERR.
    - If N == 0, go to CSUM.
    - Otherwise go to DATA.
  - DATA (in_ready=1): on accept at cycle t, in cycle t+1 drive wr_en=1, wr_addr=counter, wr_data=byte. Then counter+=1 and sum+=byte (8-bit wrap). After the N-th accept, go to CSUM.
  - CSUM (in_ready=1): on accept at cycle k, compare the byte with sum.
    - Mismatch: go to ERR. error=1, busy=0, cpu_hold=1 from cycle k+1; no fill writes.
    - Match: go to FILL, unless N == MEM_DEPTH, in which case go straight to DONE.
  - FILL (in_ready=0): one write per cycle, wr_addr=N..MEM_DEPTH-1, wr_data=FILL_BYTE, during cycles k+1..k+(MEM_DEPTH−N). Then go to DONE.
  - DONE: done=1, busy=0, cpu_hold=0 from the cycle after the last write. Held until the next start.
- in_ready=0 outside LEN/DATA/CSUM. wr_en is never asserted outside a DATA-accept follow cycle or FILL.
- start while busy is ignored; the current load continues unchanged.
- wr_addr never exceeds MEM_DEPTH-1. The counter is ADDR_WIDTH+1 bits internally, so MEM_DEPTH=2^ADDR_WIDTH does not wrap early.
- Throughput: one data byte per cycle with in_valid held high; no bubbles between DATA and CSUM.

Test Plan:
- Reset check: hold rst 2 cycles → in_ready=0, wr_en=0, busy=0, done=0, error=0, cpu_hold=1. in_valid alone does nothing with no start.
- Good load: start, then stream 03 A1 B2 C3 16 back-to-back → writes (0,A1),(1,B2),(2,C3) one cycle after each accept. Then 253 fill writes of 00 at addresses 3..255. Then done=1, cpu_hold=0, busy=0.
- Bad checksum: stream 03 A1 B2 C3 17 → three data writes, error=1 the cycle after CSUM accept, no fill writes, cpu_hold=1, done=0.
- Empty program: stream 00 00 → 256 fill writes at addresses 0..255, then done=1.
- Backpressure/gaps: stream 02 10 20 30 with in_valid deasserted for 1–3 random cycles between bytes → writes only at addresses 0,1 with 10,20, contiguous. Checksum 30 accepted, fill runs from address 2.
- Start-while-busy and mid-load reset: pulse start during DATA → ignored. Assert rst after 2 data bytes → reset values next edge. A new start then performs a full good load correctly.
